demux_tdm_sequencer: RTL
========================

# demux_tdm_sequencer

Upstream driver for the 8-output, 3-bit-select demux. Accepts an 8-bit data word plus an 8-bit channel-enable mask over a valid/ready handshake. It then walks the enabled channels in ascending order, presenting one channel per slot on `sel[2:0]`/`din` with a qualifying `strobe`. Each demux output `out[i]` therefore receives `data[i]` during its slot, and the stream forms a time-division-multiplexed fan-out of one word.

## Interface
- `HOLD_CYCLES`, default 1: number of clock cycles each channel slot is held. Legal range is 1..16; the slot counter is 4 bits.

- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream word valid.
- `in_ready` out 1: block can accept a word.
- `in_data` in 8: word; bit i is destined for demux output i.
- `in_mask` in 8: bit i = 1 means channel i gets a slot; 0 means it is skipped.
- `flush` in 1: synchronous abort of the current word.
- `sel` out 3: demux select (channel index).
- `din` out 1: demux data input.
- `strobe` out 1: `sel`/`din` valid this cycle.
- `busy` out 1: a word is being sequenced.
- `done` out 1: one-cycle pulse after the last slot of a word.

## Operation
- FSM states: IDLE and SCAN. Registers: `data_q[7:0]`, `mask_q[7:0]`, `ptr[2:0]`, `hold_cnt[3:0]`.
- Outputs `sel`, `din`, `strobe` and `done` are registered.
- `in_ready` = (state == IDLE). `busy` = (state == SCAN).
- **Accept:** a word is accepted on an edge where `in_valid && in_ready && !flush`.
  - `mask` ≠ 0: latch the word and mask, set `ptr` to the lowest set mask bit, clear `hold_cnt`, go to SCAN.
  - `mask` = 0: stay in IDLE and pulse `done` the next cycle. No strobes are issued.
- **SCAN:**
  - Drive `sel` = `ptr`, `din` = `data_q[ptr]`, `strobe` = 1.
  - `hold_cnt` increments each cycle. When it reaches `HOLD_CYCLES`-1, advance `ptr` to the next set bit of `mask_q` strictly above `ptr` and clear `hold_cnt`.
  - If no higher set bit exists, go to IDLE and pulse `done`.
  - Skipped channels consume zero cycles.
- **Outside SCAN:**
  - `strobe` = 0 and `din` = 0.
  - `sel` holds its last driven value. The demux still routes `din` = 0 to that channel, which is harmless.
- **`flush`:**
  - In any state, the next state is IDLE, and `strobe`, `din` and `hold_cnt` clear.
  - No `done` pulse is generated, and any `done` that would have fired is suppressed.
  - `flush` has priority over accept, so a word offered with `flush`=1 is not accepted.
- **Cross-word isolation:** `in_data` and `in_mask` changes during SCAN have no effect, because only the latched copies are used.
- **Ordering:** channels are always visited in ascending index order. `ptr` never wraps from 7 back to 0 within a word.

## Timing
- **Reset values (while `rst_n` = 0):** state=IDLE, `sel`=0, `din`=0, `strobe`=0, `done`=0, `busy`=0, `in_ready`=1. All internal registers are 0.
- **Latency:** word accepted on edge k → first `strobe` high in the cycle after edge k.
- **Word duration:** popcount(mask)×`HOLD_CYCLES` strobe cycles, contiguous.
- **`done` timing:** `done` is high for exactly one cycle, on the first cycle after the last strobe cycle. `in_ready` is also 1 in that cycle, so a new word may be accepted there.
- **Throughput:** sustained rate is one word per popcount×`HOLD_CYCLES`+1 cycles. A mask=0 word costs 1 cycle.
- **Slot stability:** `sel` and `din` are stable for all `HOLD_CYCLES` cycles of a slot. They change only at slot boundaries.
- **Reset mid-SCAN:** all outputs return to reset values immediately. No `done` is produced.

## Test plan
- **Full mask:** `HOLD_CYCLES`=1, data=0xA5, mask=0xFF → 8 consecutive strobes, `sel` 0..7, `din` 1,0,1,0,0,1,0,1. `done` is seen 1 cycle after `sel`=7. A demux scoreboard sees `out[i]` = data[i] in slot i.
- **Sparse mask:** data=0xFF, mask=0x81 → exactly 2 strobes, `sel`=0 then `sel`=7, with no gap cycles. `done` on the next cycle.
- **Empty mask:** mask=0x00 → no strobe and `in_ready` stays 1. `done` pulses exactly once, 1 cycle after accept.
- **Hold and back-to-back:** `HOLD_CYCLES`=3, mask=0x06, data=0x04 → `sel`=1/`din`=0 for 3 cycles, then `sel`=2/`din`=1 for 3 cycles. `done`, then a second word with `in_valid` held high is accepted in the `done` cycle. Meanwhile, changing `in_data` during SCAN has no effect on `din`.
- **Flush:** assert `flush` on the 2nd strobe of a mask=0xFF word → `strobe`=0 on the next cycle, no `done`, `in_ready`=1. A following word with mask=0x08 sequences normally with a single strobe on `sel`=3.
- **Async reset:** drop `rst_n` mid-SCAN, asynchronously to `clk` → `strobe`, `din`, `sel` and `busy` go to 0 without a clock edge. After release, the next accepted word starts from its lowest mask bit.

Source files
------------

// File: rtl/demux_tdm_sequencer.sv
// Drives an 8-way demux with one latched word: every enabled channel gets a
// strobed slot of HOLD_CYCLES cycles on sel/din, visited in ascending order.
module demux_tdm_sequencer #(
   parameter int unsigned HOLD_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic [7:0] in_mask,
   input  logic       flush,
   output logic [2:0] sel,
   output logic       din,
   output logic       strobe,
   output logic       busy,
   output logic       done
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

   state_t     state_q, state_d;
   logic [7:0] data_q, data_d;
   logic [7:0] mask_q, mask_d;
   logic [2:0] ptr_q, ptr_d;
   logic [3:0] hold_cnt_q, hold_cnt_d;
   logic [2:0] sel_q, sel_d;
   logic       din_q, din_d;
   logic       strobe_q, strobe_d;
   logic       done_q, done_d;

   logic [2:0] first_idx;
   logic [3:0] next_hit;

   // Lowest set bit of m (0 when m is empty; callers check m first).
   function automatic logic [2:0] lowest_bit(input logic [7:0] m);
      logic [2:0] r;
      r = '0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) r = 3'(i);
      end
      return r;
   endfunction

   // {found, index} of the lowest set bit of m strictly above p; never wraps.
   function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] p);
      logic [3:0] r;
      r = '0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i] && (3'(i) > p)) r = {1'b1, 3'(i)};
      end
      return r;
   endfunction

   assign first_idx = lowest_bit(in_mask);
   assign next_hit  = next_above(mask_q, ptr_q);

   always_comb begin
      // NOTE: every target gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_d    = state_q;
      data_d     = data_q;
      mask_d     = mask_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      sel_d      = sel_q;
      din_d      = din_q;
      strobe_d   = strobe_q;
      done_d     = 1'b0;

      if (flush) begin
         state_d    = IDLE;
         strobe_d   = 1'b0;
         din_d      = 1'b0;
         hold_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  if (in_mask != 8'h00) begin
                     data_d     = in_data;
                     mask_d     = in_mask;
                     ptr_d      = first_idx;
                     hold_cnt_d = '0;
                     sel_d      = first_idx;
                     din_d      = in_data[first_idx];
                     strobe_d   = 1'b1;
                     state_d    = SCAN;
                  end else begin
                     done_d = 1'b1;
                  end
               end
            end
            SCAN: begin
               if (hold_cnt_q == HOLD_LAST) begin
                  hold_cnt_d = '0;
                  if (next_hit[3]) begin
                     ptr_d = next_hit[2:0];
                     sel_d = next_hit[2:0];
                     din_d = data_q[next_hit[2:0]];
                  end else begin
                     state_d  = IDLE;
                     strobe_d = 1'b0;
                     din_d    = 1'b0;
                     done_d   = 1'b1;
                  end
               end else begin
                  hold_cnt_d = hold_cnt_q + 4'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         data_q     <= '0;
         mask_q     <= '0;
         ptr_q      <= '0;
         hold_cnt_q <= '0;
         sel_q      <= '0;
         din_q      <= 1'b0;
         strobe_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every flop samples the pre-edge value of every other flop.
         state_q    <= state_d;
         data_q     <= data_d;
         mask_q     <= mask_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         sel_q      <= sel_d;
         din_q      <= din_d;
         strobe_q   <= strobe_d;
         done_q     <= done_d;
      end
   end

   assign in_ready = (state_q == IDLE);
   assign busy     = (state_q == SCAN);
   assign sel      = sel_q;
   assign din      = din_q;
   assign strobe   = strobe_q;
   assign done     = done_q;

endmodule
